// File: rtl/cdc_bus_fifo_pkg.sv
// Shared constants for the cdc_bus_fifo bridge: register addresses, status and CTRL bit positions.
package cdc_bus_fifo_pkg;

  localparam logic [1:0] ADDR_CTRL    = 2'b00;
  localparam logic [1:0] ADDR_IN      = 2'b01;
  localparam logic [1:0] ADDR_OUTST   = 2'b10;
  localparam logic [1:0] ADDR_OUTDATA = 2'b11;

  // IN status (address 01)
  localparam int ST_NOTFULL  = 0;
  localparam int ST_EMPTY    = 1;
  // OUT status (address 10)
  localparam int ST_NOTEMPTY = 0;
  localparam int ST_FULL     = 1;
  // Sticky error flag, both status registers
  localparam int ST_ERR      = 7;

  localparam int CTRL_IN_IRQ_EN  = 0;
  localparam int CTRL_OUT_IRQ_EN = 1;
  localparam logic [1:0] CTRL_RESET = 2'b11;

endpackage

// File: rtl/cdc_bus_fifo_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; push on full succeeds only when a pop frees the slot.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is deliberately not reset; empty pointers make stale contents unreachable.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/cdc_bus_fifo.sv
// Bus-mapped IN/OUT byte FIFO bridge to USB_CDC with event IRQs.
// Define CDC_BUS_FIFO_ERR_EN to build sticky overflow/underflow flags in status bit 7.
module cdc_bus_fifo
  import cdc_bus_fifo_pkg::*;
#(
  parameter int IN_DEPTH  = 8,
  parameter int OUT_DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       sel_i,
  input  logic       read_i,
  input  logic       write_i,
  input  logic [1:0] addr_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       in_irq_o,
  output logic       out_irq_o,
  output logic [7:0] in_data_o,
  output logic       in_valid_o,
  input  logic       in_ready_i,
  input  logic [7:0] out_data_i,
  input  logic       out_valid_i,
  output logic       out_ready_o
);

  // Streams use valid/ready: a byte moves on any clock edge where valid and ready are both high;
  // the source holds data stable while valid is high and not yet accepted.

  logic       wr_en, rd_en;
  logic       in_push, in_pop, in_full, in_empty;
  logic       out_push, out_pop, out_full, out_empty;
  logic [7:0] out_head;
  logic [1:0] ctrl_q, ctrl_d;
  logic [7:0] data_q, rdata_d;
  logic       in_irq_q, out_irq_q;
  logic       rdy_q;
  logic       ovf_flag, unf_flag;

  // A simultaneous write wins; the read is suppressed so data_o holds.
  assign wr_en = sel_i & write_i;
  assign rd_en = sel_i & read_i & ~write_i;

  assign in_push  = wr_en & (addr_i == ADDR_IN);
  assign in_pop   = in_valid_o & in_ready_i;
  assign out_push = out_valid_i & out_ready_o;
  assign out_pop  = rd_en & (addr_i == ADDR_OUTDATA);

  sync_fifo #(.WIDTH(8), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (in_push),
    .data_i  (data_i),
    .pop_i   (in_pop),
    .data_o  (in_data_o),
    .full_o  (in_full),
    .empty_o (in_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (out_push),
    .data_i  (out_data_i),
    .pop_i   (out_pop),
    .data_o  (out_head),
    .full_o  (out_full),
    .empty_o (out_empty)
  );

  assign in_valid_o  = ~in_empty;
  // rdy_q keeps ready low during reset and until the first edge after release.
  assign out_ready_o = rdy_q & ~out_full;

`ifdef CDC_BUS_FIFO_ERR_EN
  logic ovf_q, ovf_d, unf_q, unf_d;

  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (rd_en && addr_i == ADDR_IN)    ovf_d = 1'b0;
    if (rd_en && addr_i == ADDR_OUTST) unf_d = 1'b0;
    // Overflow means the byte was really dropped: full with no stream pop freeing a slot.
    if (in_push && in_full && !in_pop) ovf_d = 1'b1;
    if (out_pop && out_empty)          unf_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ovf_flag = ovf_q;
  assign unf_flag = unf_q;
`else
  assign ovf_flag = 1'b0;
  assign unf_flag = 1'b0;
`endif

  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_en && addr_i == ADDR_CTRL) ctrl_d = data_i[1:0];
  end

  // Status is taken from pre-transfer FIFO state; flags return their value before any clear.
  always_comb begin
    rdata_d = '0;
    case (addr_i)
      ADDR_CTRL: rdata_d[1:0] = ctrl_q;
      ADDR_IN: begin
        rdata_d[ST_NOTFULL] = ~in_full;
        rdata_d[ST_EMPTY]   = in_empty;
        rdata_d[ST_ERR]     = ovf_flag;
      end
      ADDR_OUTST: begin
        rdata_d[ST_NOTEMPTY] = ~out_empty;
        rdata_d[ST_FULL]     = out_full;
        rdata_d[ST_ERR]      = unf_flag;
      end
      default: rdata_d = out_empty ? 8'h00 : out_head;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ctrl_q    <= CTRL_RESET;
      data_q    <= '0;
      in_irq_q  <= 1'b0;
      out_irq_q <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      if (rd_en) data_q <= rdata_d;
      in_irq_q  <= in_pop & ctrl_q[CTRL_IN_IRQ_EN];
      out_irq_q <= out_push & ctrl_q[CTRL_OUT_IRQ_EN];
      rdy_q     <= 1'b1;
    end
  end

  assign data_o    = data_q;
  assign in_irq_o  = in_irq_q;
  assign out_irq_o = out_irq_q;

endmodule

// File: tb/tb_cdc_bus_fifo.sv
// Directed bench for cdc_bus_fifo: bus register access, both streams, IRQ gating and reset.
module tb_cdc_bus_fifo;

  logic       clk_i = 1'b0;
  logic       rstn_i = 1'b0;
  logic       sel_i = 1'b0;
  logic       read_i = 1'b0;
  logic       write_i = 1'b0;
  logic [1:0] addr_i = 2'b00;
  logic [7:0] data_i = 8'h00;
  logic [7:0] data_o;
  logic       in_irq_o, out_irq_o;
  logic [7:0] in_data_o;
  logic       in_valid_o;
  logic       in_ready_i = 1'b0;
  logic [7:0] out_data_i = 8'h00;
  logic       out_valid_i = 1'b0;
  logic       out_ready_o;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  cdc_bus_fifo #(.IN_DEPTH(8), .OUT_DEPTH(8)) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .sel_i       (sel_i),
    .read_i      (read_i),
    .write_i     (write_i),
    .addr_i      (addr_i),
    .data_i      (data_i),
    .data_o      (data_o),
    .in_irq_o    (in_irq_o),
    .out_irq_o   (out_irq_o),
    .in_data_o   (in_data_o),
    .in_valid_o  (in_valid_o),
    .in_ready_i  (in_ready_i),
    .out_data_i  (out_data_i),
    .out_valid_i (out_valid_i),
    .out_ready_o (out_ready_o)
  );

  // Clock / reset block: 10 ns period; inputs change and outputs are sampled on negedges.
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk_i);
    sel_i = 1'b1; write_i = 1'b1; addr_i = a; data_i = d;
    @(negedge clk_i);
    sel_i = 1'b0; write_i = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk_i);
    sel_i = 1'b1; read_i = 1'b1; addr_i = a;
    @(negedge clk_i);
    sel_i = 1'b0; read_i = 1'b0;
    d = data_o;
  endtask

  task automatic out_send(input logic [7:0] d, output logic irq);
    @(negedge clk_i);
    out_valid_i = 1'b1; out_data_i = d;
    check("out_send_ready", out_ready_o, 1'b1);
    @(negedge clk_i);
    out_valid_i = 1'b0;
    irq = out_irq_o;
  endtask

  // Open the IN stream for a fixed window, collecting bytes and IRQ pulses.
  task automatic drain_in(input int cycles, output int irqs);
    got_q.delete();
    irqs = 0;
    @(negedge clk_i);
    in_ready_i = 1'b1;
    repeat (cycles) begin
      if (in_valid_o) got_q.push_back(in_data_o);
      @(negedge clk_i);
      if (in_irq_o) irqs++;
    end
    in_ready_i = 1'b0;
  endtask

  // Scoreboard: compare collected IN bytes against the expected queue.
  task automatic score_in(input string tag);
    int n;
    logic [7:0] e, g;
    n = exp_q.size();
    check({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      check(tag, g, e);
    end
  endtask

  initial begin
    logic [7:0] rd;
    logic irq;
    int irqs;

    // 1. Reset state
    repeat (2) @(negedge clk_i);
    check("rst_out_ready_low", out_ready_o, 1'b0);
    check("rst_in_valid", in_valid_o, 1'b0);
    check("rst_data_o", data_o, 8'h00);
    rstn_i = 1'b1;
    check("release_out_ready_still_low", out_ready_o, 1'b0);
    @(negedge clk_i);
    check("post_release_out_ready", out_ready_o, 1'b1);
    bus_read(2'b00, rd); check("rst_ctrl", rd, 8'h03);
    bus_read(2'b01, rd); check("rst_in_status", rd, 8'h03);
    bus_read(2'b10, rd); check("rst_out_status", rd, 8'h00);
    check("rst_irqs", {in_irq_o, out_irq_o}, 2'b00);

    // 2. Fill IN with 0x41..0x48, then stream it out
    for (int i = 0; i < 8; i++) begin
      bus_write(2'b01, 8'h41 + 8'(i));
      exp_q.push_back(8'h41 + 8'(i));
    end
    bus_read(2'b01, rd); check("in_full_status", rd, 8'h00);
    check("in_valid_full", in_valid_o, 1'b1);
    drain_in(12, irqs);
    score_in("in_stream");
    check("in_irq_pulses", irqs, 8);
    bus_read(2'b01, rd); check("in_drained_status", rd, 8'h03);

    // 3. Fill OUT with 0x30..0x37, hold 0x38 while full, then pop
    for (int i = 0; i < 8; i++) out_send(8'h30 + 8'(i), irq);
    @(negedge clk_i);
    out_valid_i = 1'b1; out_data_i = 8'h38;
    check("out_full_ready_low", out_ready_o, 1'b0);
    bus_read(2'b10, rd); check("out_full_status", rd, 8'h03);
    bus_read(2'b11, rd); check("out_pop_0", rd, 8'h30);
    check("out_ready_after_pop", out_ready_o, 1'b1);
    @(negedge clk_i);
    out_valid_i = 1'b0;
    for (int i = 1; i < 8; i++) begin
      bus_read(2'b11, rd); check("out_pop", rd, 8'h30 + 8'(i));
    end
    bus_read(2'b10, rd); check("out_one_left_status", rd, 8'h01);

    // 4. Pop the last byte, then underflow
    bus_read(2'b11, rd); check("out_pop_9th", rd, 8'h38);
    bus_read(2'b11, rd); check("out_pop_empty", rd, 8'h00);
`ifdef CDC_BUS_FIFO_ERR_EN
    bus_read(2'b10, rd); check("underflow_flag_set", rd, 8'h80);
`else
    bus_read(2'b10, rd); check("underflow_no_flag", rd, 8'h00);
`endif
    bus_read(2'b10, rd); check("underflow_flag_clear", rd, 8'h00);
    out_send(8'h3a, irq);
    bus_read(2'b10, rd); check("ptrs_intact_status", rd, 8'h01);
    bus_read(2'b11, rd); check("ptrs_intact_data", rd, 8'h3a);

    // 5. IRQ enable gating
    bus_write(2'b00, 8'h00);
    bus_read(2'b00, rd); check("ctrl_cleared", rd, 8'h00);
    out_send(8'h61, irq); check("out_irq_disabled", irq, 1'b0);
    bus_read(2'b10, rd); check("out_status_0x61", rd, 8'h01);
    bus_read(2'b11, rd); check("out_pop_0x61", rd, 8'h61);
    bus_write(2'b00, 8'h02);
    out_send(8'h62, irq); check("out_irq_enabled", irq, 1'b1);
    @(negedge clk_i);
    check("out_irq_one_cycle", out_irq_o, 1'b0);
    bus_read(2'b11, rd); check("out_pop_0x62", rd, 8'h62);

    // 6. Push on full with a same-cycle stream pop; in_irq now disabled
    for (int i = 0; i < 8; i++) bus_write(2'b01, 8'h50 + 8'(i));
    @(negedge clk_i);
    sel_i = 1'b1; write_i = 1'b1; addr_i = 2'b01; data_i = 8'h58; in_ready_i = 1'b1;
    @(negedge clk_i);
    sel_i = 1'b0; write_i = 1'b0; in_ready_i = 1'b0;
    bus_read(2'b01, rd); check("in_still_full", rd, 8'h00);
    for (int i = 1; i <= 8; i++) exp_q.push_back(8'h50 + 8'(i));
    drain_in(12, irqs);
    score_in("in_push_pop");
    check("in_irq_disabled", irqs, 0);

    // Asynchronous reset in the middle of a stream
    bus_write(2'b01, 8'ha0);
    bus_write(2'b01, 8'ha1);
    @(negedge clk_i);
    in_ready_i = 1'b1;
    check("in_valid_before_rst", in_valid_o, 1'b1);
    #2 rstn_i = 1'b0;
    #1;
    check("async_rst_in_valid", in_valid_o, 1'b0);
    check("async_rst_out_ready", out_ready_o, 1'b0);
    check("async_rst_data_o", data_o, 8'h00);
    @(negedge clk_i);
    in_ready_i = 1'b0;
    rstn_i = 1'b1;
    @(negedge clk_i);
    check("rerelease_out_ready", out_ready_o, 1'b1);
    bus_read(2'b01, rd); check("rst_in_emptied", rd, 8'h03);
    bus_read(2'b00, rd); check("rst_ctrl_restored", rd, 8'h03);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
